// File: rtl/alu16_sequencer.sv
// Two-pass 16-bit arithmetic sequencer: ADD HL,rr / ADD SP,e8 / INC rr / DEC rr
// computed as a low-byte pass and a high-byte pass through one shared byte adder.

module n_bit_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout,
  output logic         o_half_carry
);
  logic [N:0] full_sum;
  logic [4:0] nibble_sum;

  assign full_sum     = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
  // Half carry is the carry out of bit 3 of this pass.
  assign nibble_sum   = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0000, i_cin};
  assign o_sum        = full_sum[N-1:0];
  assign o_cout       = full_sum[N];
  assign o_half_carry = nibble_sum[4];
endmodule

module alu16_sequencer #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic [WORD_WIDTH-1:0] i_operand_A,
  input  logic [WORD_WIDTH-1:0] i_operand_B,
  input  logic [3:0]            i_flags,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [WORD_WIDTH-1:0] o_result,
  output logic [3:0]            o_flags
);
  localparam int HW = WORD_WIDTH / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD16   = 2'b00,
    OP_ADDSPE8 = 2'b01,
    OP_INC16   = 2'b10,
    OP_DEC16   = 2'b11
  } op_e;

  // Handshake: i_start is taken only on an edge where the sequencer is IDLE
  // (o_busy=0); otherwise it is dropped. o_done pulses for one cycle when the
  // result lands, and o_result/o_flags then hold until the next completion.

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [WORD_WIDTH-1:0]   opa_q, opa_d;
  logic [WORD_WIDTH-1:0]   opb_q, opb_d;
  logic [3:0]              flags_in_q, flags_in_d;
  logic [HW-1:0]           sum_lo_q, sum_lo_d;
  logic [HW-1:0]           sum_hi_q, sum_hi_d;
  logic                    lo_carry_q, lo_carry_d;
  logic                    lo_half_q, lo_half_d;
  logic                    hi_carry_q, hi_carry_d;
  logic                    hi_half_q, hi_half_d;
  logic [WORD_WIDTH-1:0]   result_q, result_d;
  logic [3:0]              flags_out_q, flags_out_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic [HW-1:0]           add_a;
  logic [HW-1:0]           add_b;
  logic                    add_cin;
  logic [HW-1:0]           add_sum;
  logic                    add_cout;
  logic                    add_half;

  n_bit_adder #(.N(HW)) u_adder (
    .i_a          (add_a),
    .i_b          (add_b),
    .i_cin        (add_cin),
    .o_sum        (add_sum),
    .o_cout       (add_cout),
    .o_half_carry (add_half)
  );

  // Adder operand steering: the HI pass chains the carry registered by LO.
  always_comb begin
    add_a   = opa_q[HW-1:0];
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == ST_HI) begin
      add_a   = opa_q[WORD_WIDTH-1:HW];
      add_cin = lo_carry_q;
      case (op_q)
        OP_ADD16:   add_b = opb_q[WORD_WIDTH-1:HW];
        OP_ADDSPE8: add_b = {HW{opb_q[HW-1]}};
        OP_INC16:   add_b = '0;
        OP_DEC16:   add_b = '1;
        default:    add_b = '0;
      endcase
    end else begin
      case (op_q)
        OP_ADD16:   add_b = opb_q[HW-1:0];
        OP_ADDSPE8: add_b = opb_q[HW-1:0];
        OP_INC16:   add_b = {{(HW-1){1'b0}}, 1'b1};
        OP_DEC16:   add_b = '1;
        default:    add_b = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    flags_in_d  = flags_in_q;
    sum_lo_d    = sum_lo_q;
    sum_hi_d    = sum_hi_q;
    lo_carry_d  = lo_carry_q;
    lo_half_d   = lo_half_q;
    hi_carry_d  = hi_carry_q;
    hi_half_d   = hi_half_q;
    result_d    = result_q;
    flags_out_d = flags_out_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          op_d       = op_e'(i_op);
          opa_d      = i_operand_A;
          opb_d      = i_operand_B;
          flags_in_d = i_flags;
          state_d    = ST_LO;
        end
      end
      ST_LO: begin
        sum_lo_d   = add_sum;
        lo_carry_d = add_cout;
        lo_half_d  = add_half;
        state_d    = ST_HI;
      end
      ST_HI: begin
        sum_hi_d   = add_sum;
        hi_carry_d = add_cout;
        hi_half_d  = add_half;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        result_d = {sum_hi_q, sum_lo_q};
        case (op_q)
          OP_ADD16:   flags_out_d = {flags_in_q[3], 1'b0, hi_half_q, hi_carry_q};
          OP_ADDSPE8: flags_out_d = {2'b00, lo_half_q, lo_carry_q};
          default:    flags_out_d = flags_in_q;
        endcase
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD16;
      opa_q       <= '0;
      opb_q       <= '0;
      flags_in_q  <= 4'h0;
      sum_lo_q    <= '0;
      sum_hi_q    <= '0;
      lo_carry_q  <= 1'b0;
      lo_half_q   <= 1'b0;
      hi_carry_q  <= 1'b0;
      hi_half_q   <= 1'b0;
      result_q    <= '0;
      flags_out_q <= 4'h0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      flags_in_q  <= flags_in_d;
      sum_lo_q    <= sum_lo_d;
      sum_hi_q    <= sum_hi_d;
      lo_carry_q  <= lo_carry_d;
      lo_half_q   <= lo_half_d;
      hi_carry_q  <= hi_carry_d;
      hi_half_q   <= hi_half_d;
      result_q    <= result_d;
      flags_out_q <= flags_out_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;
  assign o_flags  = flags_out_q;
endmodule

// File: tb/tb_alu16_sequencer.sv
// Self-checking bench for alu16_sequencer: expected {flags,result} values are
// queued when an op is driven and compared against what o_done delivers.

module tb_alu16_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic [3:0]  fl = 4'h0;
  logic        busy;
  logic        done;
  logic [15:0] res;
  logic [3:0]  fo;

  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];
  int          exp_cyc_q[$];
  int          obs_cyc_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  alu16_sequencer #(.WORD_WIDTH(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_op        (op),
    .i_operand_A (a),
    .i_operand_B (b),
    .i_flags     (fl),
    .o_busy      (busy),
    .o_done      (done),
    .o_result    (res),
    .o_flags     (fo)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every o_done pulse is captured with its cycle stamp.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      obs_q.push_back({fo, res});
      obs_cyc_q.push_back(cyc);
    end
  end

  // Reference model: whole-word arithmetic, flags from the bit-position carries.
  function automatic logic [19:0] model(input logic [1:0] o, input logic [15:0] x,
                                        input logic [15:0] y, input logic [3:0] f);
    logic [16:0] s17;
    logic [12:0] h13;
    logic [4:0]  h5;
    logic [8:0]  c9;
    logic [15:0] r;
    logic [3:0]  nf;
    case (o)
      2'b00: begin
        s17 = {1'b0, x} + {1'b0, y};
        h13 = {1'b0, x[11:0]} + {1'b0, y[11:0]};
        r   = s17[15:0];
        nf  = {f[3], 1'b0, h13[12], s17[16]};
      end
      2'b01: begin
        r  = x + {{8{y[7]}}, y[7:0]};
        h5 = {1'b0, x[3:0]} + {1'b0, y[3:0]};
        c9 = {1'b0, x[7:0]} + {1'b0, y[7:0]};
        nf = {2'b00, h5[4], c9[8]};
      end
      2'b10: begin
        r  = x + 16'd1;
        nf = f;
      end
      default: begin
        r  = x - 16'd1;
        nf = f;
      end
    endcase
    return {nf, r};
  endfunction

  // Driver: one-cycle start pulse, then scramble inputs to prove they are latched.
  task automatic drive_op(input logic [1:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic [3:0] f);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; fl = f;
    exp_q.push_back(model(o, x, y, f));
    exp_cyc_q.push_back(cyc + 4);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    a  = 16'($urandom);
    b  = 16'($urandom);
    fl = 4'($urandom);
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk);
    #1;
  endtask

  task automatic flush_queues();
    exp_q.delete(); exp_cyc_q.delete(); obs_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++;
    if (res !== 16'h0000) begin n_errors++; $display("FAIL reset_result got %h want 0000", res); end
    n_checks++;
    if (fo !== 4'h0) begin n_errors++; $display("FAIL reset_flags got %b want 0000", fo); end
    // Reset and start together: reset wins.
    start = 1'b1; op = 2'b00; a = 16'h1234; b = 16'h4321; fl = 4'hF;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_start_busy got %b want 0", busy); end
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 0) begin
      n_errors++; $display("FAIL rst_start_done got %0d pulses want 0", obs_q.size());
    end
    flush_queues();
  endtask

  task automatic test_add16();
    logic [15:0] ta [2] = '{16'h8A23, 16'hFFFF};
    logic [15:0] tb [2] = '{16'h0605, 16'h0001};
    logic [3:0]  tf [2] = '{4'b1000, 4'b0100};
    logic [19:0] got, want;
    int          gc, wc;
    for (int i = 0; i < 2; i++) begin
      drive_op(2'b00, ta[i], tb[i], tf[i]);
      n_checks++;
      if (busy !== 1'b1) begin n_errors++; $display("FAIL add16_busy[%0d] got %b want 1", i, busy); end
      wait_obs(1, 20);
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++; $display("FAIL add16_timeout[%0d] got no o_done want 1 pulse", i);
        flush_queues();
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        gc = obs_cyc_q.pop_front(); wc = exp_cyc_q.pop_front();
        if (got !== want) begin n_errors++; $display("FAIL add16_result[%0d] got %h want %h", i, got, want); end
        n_checks++;
        if (gc !== wc) begin n_errors++; $display("FAIL add16_latency[%0d] got cycle %0d want %0d", i, gc, wc); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL add16_idle[%0d] got busy %b want 0", i, busy); end
      end
    end
    // Outputs hold after the done pulse.
    @(negedge clk);
    n_checks++;
    if ({fo, res} !== 20'h3_0000 || done !== 1'b0) begin
      n_errors++; $display("FAIL add16_hold got done %b %h want done 0 30000", done, {fo, res});
    end
  endtask

  task automatic test_addspe8();
    logic [15:0] ta [3] = '{16'hFFF8, 16'h1000, 16'h0F7F};
    logic [15:0] tb [3] = '{16'h0008, 16'h00FF, 16'hAB81};
    logic [3:0]  tf [3] = '{4'b1111, 4'b0000, 4'b1010};
    logic [19:0] got, want;
    for (int i = 0; i < 3; i++) begin
      drive_op(2'b01, ta[i], tb[i], tf[i]);
      wait_obs(1, 20);
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++; $display("FAIL spe8_timeout[%0d] got no o_done want 1 pulse", i);
        flush_queues();
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        void'(obs_cyc_q.pop_front()); void'(exp_cyc_q.pop_front());
        if (got !== want) begin n_errors++; $display("FAIL spe8_result[%0d] got %h want %h", i, got, want); end
      end
    end
  endtask

  task automatic test_inc_dec();
    logic [1:0]  to [4] = '{2'b11, 2'b10, 2'b10, 2'b11};
    logic [15:0] ta [4] = '{16'h0000, 16'hFFFF, 16'h00FF, 16'h0100};
    logic [3:0]  tf [4] = '{4'b0101, 4'b1010, 4'b0011, 4'b1100};
    logic [19:0] got, want;
    for (int i = 0; i < 4; i++) begin
      drive_op(to[i], ta[i], 16'($urandom), tf[i]);
      wait_obs(1, 20);
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++; $display("FAIL incdec_timeout[%0d] got no o_done want 1 pulse", i);
        flush_queues();
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        void'(obs_cyc_q.pop_front()); void'(exp_cyc_q.pop_front());
        if (got !== want) begin n_errors++; $display("FAIL incdec_result[%0d] got %h want %h", i, got, want); end
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] got, want;
    for (int i = 0; i < 12; i++) begin
      drive_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 4'($urandom));
      wait_obs(1, 20);
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++; $display("FAIL rand_timeout[%0d] got no o_done want 1 pulse", i);
        flush_queues();
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        void'(obs_cyc_q.pop_front()); void'(exp_cyc_q.pop_front());
        if (got !== want) begin n_errors++; $display("FAIL rand_result[%0d] got %h want %h", i, got, want); end
      end
    end
  endtask

  // start held for 8 cycles: only the IDLE-cycle requests (0 and 4) are taken.
  task automatic test_back_to_back();
    logic [1:0]  o;
    logic [15:0] x, y;
    logic [3:0]  f;
    logic [19:0] got, want;
    int          gc, wc;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3)); x = 16'($urandom); y = 16'($urandom); f = 4'($urandom);
      start = 1'b1; op = o; a = x; b = y; fl = f;
      if (i == 0 || i == 4) begin
        exp_q.push_back(model(o, x, y, f));
        exp_cyc_q.push_back(cyc + 4);
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 2) begin
      n_errors++; $display("FAIL b2b_count got %0d ops want 2", obs_q.size());
    end
    for (int k = 0; k < 2; k++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        gc = obs_cyc_q.pop_front(); wc = exp_cyc_q.pop_front();
        n_checks++;
        if (got !== want) begin n_errors++; $display("FAIL b2b_result[%0d] got %h want %h", k, got, want); end
        n_checks++;
        if (gc !== wc) begin n_errors++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", k, gc, wc); end
      end
    end
    flush_queues();
  endtask

  task automatic test_reset_mid_op();
    logic [19:0] got, want;
    drive_op(2'b00, 16'h7F7F, 16'h0181, 4'b1000);
    void'(exp_q.pop_back()); void'(exp_cyc_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL midrst_ctrl got busy %b done %b want 0 0", busy, done);
    end
    n_checks++;
    if (res !== 16'h0000 || fo !== 4'h0) begin
      n_errors++; $display("FAIL midrst_outputs got %h %b want 0000 0000", res, fo);
    end
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 0) begin
      n_errors++; $display("FAIL midrst_done got %0d pulses want 0", obs_q.size());
    end
    flush_queues();
    drive_op(2'b00, 16'h8A23, 16'h0605, 4'b1000);
    wait_obs(1, 20);
    n_checks++;
    if (obs_q.size() == 0) begin
      n_errors++; $display("FAIL midrst_after_timeout got no o_done want 1 pulse");
      flush_queues();
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      void'(obs_cyc_q.pop_front()); void'(exp_cyc_q.pop_front());
      if (got !== want) begin n_errors++; $display("FAIL midrst_after_result got %h want %h", got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_add16();
    test_addspe8();
    test_inc_dec();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
